priority_arbiter_4req: RTL and testbench

//  Sequential arbiter that shares one resource between 4 requesters. It uses the
//  4-to-2 priority-encode function (highest index wins, plus a valid flag) as its

---
 rtl/priority_arbiter_4req_pkg.sv | 18 +
 rtl/priority_arbiter_4req_if.sv | 23 ++
 rtl/priority_arbiter_4req_prio_enc4.sv | 17 +
 rtl/priority_arbiter_4req.sv | 105 ++++++++++
 tb/tb_priority_arbiter_4req.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/priority_arbiter_4req_pkg.sv
// Shared types and helpers for the 4-requester priority arbiter.
package priority_arbiter_4req_pkg;

    localparam int N_REQ = 4;

    // 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Binary requester index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] id);
        onehot4 = 4'b0001 << id;
    endfunction

endpackage

// File: rtl/priority_arbiter_4req_if.sv
// Request/grant bundle between request sources (master) and the arbiter (slave).
interface priority_arbiter_4req_if;
    import priority_arbiter_4req_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             rr_en;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done, rr_en,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done, rr_en,
        output gnt, gnt_id, busy, timeout
    );

endinterface

// File: rtl/priority_arbiter_4req_prio_enc4.sv
// Combinational 4-to-2 priority encoder: highest set index wins, v flags any set bit.
module prio_enc4 (
    input  logic [3:0] in,
    output logic [1:0] id,
    output logic       v
);

    // Highest index has priority; id defaults to 0 when nothing is set.
    always_comb begin
        v  = |in;
        id = 2'd0;
        if (in[3])      id = 2'd3;
        else if (in[2]) id = 2'd2;
        else if (in[1]) id = 2'd1;
    end

endmodule

// File: rtl/priority_arbiter_4req.sv
// Sequential arbiter for 4 requesters: grant hold, release bubble,
// optional round-robin fairness and a hold-time limit.
module priority_arbiter_4req
    import priority_arbiter_4req_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CW       = 4
) (
    input logic                    clk,
    input logic                    rst,
    priority_arbiter_4req_if.slave bus
);

    state_t           state;
    logic [CW-1:0]    hold_cnt;
    logic [1:0]       last;
    logic [N_REQ-1:0] gnt_r;
    logic [1:0]       gnt_id_r;
    logic             busy_r;
    logic             timeout_r;

    logic [N_REQ-1:0] rot_req;
    logic [N_REQ-1:0] enc_in;
    logic [1:0]       enc_id;
    logic             enc_v;
    logic [1:0]       winner;
    logic             at_limit;
    logic             grant_exit;

    // Rotate so last+1 lands on bit 3 (highest priority) and last lands on bit 0.
    always_comb begin
        rot_req = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot_req[k] = bus.req[2'(last - 2'(k))];
        end
        enc_in = bus.rr_en ? rot_req : bus.req;
    end

    prio_enc4 u_enc (
        .in (enc_in),
        .id (enc_id),
        .v  (enc_v)
    );

    // Un-rotate the encoded index back to a requester number.
    always_comb begin
        winner     = bus.rr_en ? 2'(last - enc_id) : enc_id;
        at_limit   = (hold_cnt == CW'(MAX_HOLD - 1));
        grant_exit = bus.done || !bus.req[gnt_id_r] || at_limit;
    end

    // Arbitration FSM with hold counter, rr pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last      <= 2'd3;
            gnt_r     <= '0;
            gnt_id_r  <= 2'd0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_r <= 1'b0;
                    if (enc_v) begin
                        state    <= GRANT;
                        hold_cnt <= '0;
                        last     <= winner;
                        gnt_r    <= onehot4(winner);
                        gnt_id_r <= winner;
                        busy_r   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        state     <= RELEASE;
                        gnt_r     <= '0;
                        busy_r    <= 1'b0;
                        // done wins over a coinciding hold limit.
                        timeout_r <= at_limit && !bus.done;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    timeout_r <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt_r     <= '0;
                    busy_r    <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_priority_arbiter_4req.sv
// Self-checking bench for priority_arbiter_4req with a behavioural reference model.
module tb_priority_arbiter_4req;

    localparam int MAX_HOLD = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    priority_arbiter_4req_if bus ();

    priority_arbiter_4req #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 holding, 2 turnaround.
    int         m_phase;
    int         m_holder;
    int         m_held;
    int         m_last;
    logic [3:0] e_gnt;
    logic [1:0] e_id;
    logic       e_busy;
    logic       e_to;

    function automatic int pick(input logic [3:0] r, input logic rr, input int last);
        if (!rr) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    function automatic logic [7:0] obs();
        return {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
    endfunction

    function automatic logic [7:0] expv();
        return {e_gnt, e_id, e_busy, e_to};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_holder = 0; m_held = 0; m_last = 3;
        e_gnt = '0; e_id = '0; e_busy = 1'b0; e_to = 1'b0;
    endtask

    // Advance one clock: sample inputs, update model at the edge, return at the falling edge.
    task automatic step();
        logic [3:0] r;
        logic       d, rr;
        int         w;
        r = bus.req; d = bus.done; rr = bus.rr_en;
        @(posedge clk);
        case (m_phase)
            0: begin
                e_to = 1'b0;
                if (r != 4'b0000) begin
                    w = pick(r, rr, m_last);
                    m_holder = w; m_held = 1; m_last = w; m_phase = 1;
                    e_gnt = 4'(1 << w); e_id = 2'(w); e_busy = 1'b1;
                end
            end
            1: begin
                if (d || !r[m_holder] || m_held >= MAX_HOLD) begin
                    e_to = (m_held >= MAX_HOLD) && !d;
                    m_phase = 2; e_gnt = '0; e_busy = 1'b0;
                end else begin
                    m_held++;
                end
            end
            default: begin
                e_to = 1'b0; m_phase = 0;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.req = '0; bus.done = 1'b0; bus.rr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 4'b1111; bus.done = 1'b0; bus.rr_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", obs(), 8'h00);
        end
        rst = 1'b0; bus.req = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        bus.rr_en = 1'b0; bus.req = 4'b0110;
        step();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
            failures++;
            $display("FAIL fixed_first got gnt=%b id=%0d want gnt=0100 id=2", bus.gnt, bus.gnt_id);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL fixed_hold got=%b want=%b", obs(), expv());
            end
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL fixed_release got=%b want=%b", obs(), expv());
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || obs() !== expv()) begin
            failures++;
            $display("FAIL fixed_idle_gap got=%b want=%b", obs(), expv());
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0100 || obs() !== expv()) begin
            failures++;
            $display("FAIL fixed_regrant got=%b want=%b", obs(), expv());
        end
    endtask

    task automatic test_round_robin();
        int ids[$];
        int gap;
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        do_reset();
        bus.rr_en = 1'b1; bus.req = 4'b1111;
        gap = 0;
        for (int c = 0; c < 40 && ids.size() < 5; c++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rr_model cyc=%0d got=%b want=%b", c, obs(), expv());
            end
            if (bus.gnt != 4'b0000) begin
                ids.push_back(int'(bus.gnt_id));
                if (ids.size() > 1) begin
                    checks++;
                    if (gap != 2) begin
                        failures++;
                        $display("FAIL rr_gap got=%0d want=2", gap);
                    end
                end
                gap = 0;
                bus.done = 1'b1;
            end else begin
                gap++;
                bus.done = 1'b0;
            end
        end
        bus.done = 1'b0;
        checks++;
        if (ids.size() != 5) begin
            failures++;
            $display("FAIL rr_count got=%0d want=5", ids.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ids[i] != exp_ids[i]) begin
                    failures++;
                    $display("FAIL rr_seq idx=%0d got=%0d want=%0d", i, ids[i], exp_ids[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.rr_en = 1'b0; bus.req = 4'b0001;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0 || obs() !== expv()) begin
                failures++;
                $display("FAIL timeout_hold cyc=%0d got=%b want=%b", i, obs(), expv());
            end
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1 || bus.busy !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL timeout_pulse got=%b want=%b", obs(), expv());
        end
        step();
        checks++;
        if (bus.timeout !== 1'b0 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_clear got=%b want=%b", obs(), expv());
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0001 || obs() !== expv()) begin
            failures++;
            $display("FAIL timeout_regrant got=%b want=%b", obs(), expv());
        end
    endtask

    task automatic test_abort_collision();
        do_reset();
        bus.rr_en = 1'b0; bus.req = 4'b0100;
        step(); step(); step();
        bus.req = 4'b0000;
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL abort_release got=%b want=%b", obs(), expv());
        end
        step();
        bus.req = 4'b0001;
        step();
        for (int i = 0; i < MAX_HOLD - 1; i++) step();
        checks++;
        if (bus.gnt !== 4'b0001 || obs() !== expv()) begin
            failures++;
            $display("FAIL collide_hold got=%b want=%b", obs(), expv());
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL collide_done got=%b want=%b", obs(), expv());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.rr_en = 1'b0; bus.req = 4'b0010;
        step(); step();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL areset_pre got gnt=%b want=0010", bus.gnt);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate got gnt=%b busy=%b want gnt=0000 busy=0", bus.gnt, bus.busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.rr_en = 1'b1; bus.req = 4'b1111;
        step();
        checks++;
        if (bus.gnt_id !== 2'd0 || bus.gnt !== 4'b0001 || obs() !== expv()) begin
            failures++;
            $display("FAIL areset_rr_first got=%b want=%b", obs(), expv());
        end
    endtask

    task automatic test_idle_stability();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.done  = 1'($urandom_range(0, 1));
            bus.rr_en = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (obs() !== 8'h00 || obs() !== expv()) begin
                failures++;
                $display("FAIL idle_stable cyc=%0d got=%b want=%b", i, obs(), 8'h00);
            end
        end
        bus.done = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.done  = ($urandom_range(0, 9) == 0);
            bus.rr_en = ($urandom_range(0, 31) == 0) ? ~bus.rr_en : bus.rr_en;
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs(), expv());
            end
            checks++;
            if (bus.gnt != 4'b0000 && bus.gnt !== 4'(1 << bus.gnt_id)) begin
                failures++;
                $display("FAIL random_onehot cyc=%0d got gnt=%b id=%0d", i, bus.gnt, bus.gnt_id);
            end
        end
        bus.done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_abort_collision();
        test_async_reset();
        test_idle_stability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
